// File: rtl/mac_frame_builder.sv
// Builds a 32-bit big-endian word stream: 0-3 zero bytes, a 48-bit MAC, then the
// payload words realigned behind it, with the final word zero-padded.
module mac_frame_builder #(
    parameter int unsigned BUF_BYTES = 12
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        start,
    input  logic [47:0] mac_in,
    input  logic [1:0]  offset,
    input  logic [31:0] payload_in,
    input  logic        payload_valid,
    input  logic        payload_last,
    output logic        payload_ready,
    output logic [31:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned BW = BUF_BYTES * 8;
    localparam int unsigned CW = $clog2(BUF_BYTES + 5);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_FLUSH} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_buf;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_data_out;
    logic            r_data_valid;
    logic            r_payload_ready;

    logic            w_out_free;
    logic            w_pop;
    logic            w_push;
    logic [CW-1:0]   w_count_pop;
    logic [CW-1:0]   w_count_nxt;
    logic [BW-1:0]   w_buf_pop;
    logic [BW-1:0]   w_buf_nxt;
    logic            w_stream_nxt;
    logic            w_ready_nxt;
    logic [79:0]     w_seed;
    logic            w_frame_done;

    // Accumulator: head byte lives in the top lane; unused tail bytes are kept zero,
    // so a short final pop is already zero-padded in the low lanes.
    always_comb begin
        w_out_free  = !r_data_valid || data_ready;
        w_pop       = w_out_free &&
                      (((r_state == S_STREAM) && (r_count >= CW'(4))) ||
                       ((r_state == S_FLUSH)  && (r_count != '0)));
        w_push      = (r_state == S_STREAM) && r_payload_ready && payload_valid;
        w_count_pop = r_count;
        w_buf_pop   = r_buf;
        if (w_pop) begin
            w_buf_pop   = r_buf << 32;
            w_count_pop = (r_count >= CW'(4)) ? (r_count - CW'(4)) : '0;
        end
        w_count_nxt = w_count_pop;
        w_buf_nxt   = w_buf_pop;
        if (w_push) begin
            w_count_nxt = w_count_pop + CW'(4);
            w_buf_nxt   = w_buf_pop |
                          ({payload_in, {(BW-32){1'b0}}} >> {w_count_pop, 3'b000});
        end
        w_stream_nxt = (r_state == S_STREAM) && !(w_push && payload_last);
        w_ready_nxt  = w_stream_nxt && ((32'(w_count_nxt) + 32'd4) <= BUF_BYTES);
        w_seed       = {mac_in, 32'h0} >> {offset, 3'b000};
        w_frame_done = (r_state == S_FLUSH) && (r_count == '0) && r_data_valid &&
                       data_ready && !clear;
    end

    // Start emits the first word directly so data_valid rises the cycle after start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state         <= S_IDLE;
            r_buf           <= '0;
            r_count         <= '0;
            r_data_out      <= '0;
            r_data_valid    <= 1'b0;
            r_payload_ready <= 1'b0;
        end else if (clear) begin
            r_state         <= S_IDLE;
            r_buf           <= '0;
            r_count         <= '0;
            r_data_valid    <= 1'b0;
            r_payload_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (start) begin
                        r_state         <= S_STREAM;
                        r_data_out      <= w_seed[79:48];
                        r_data_valid    <= 1'b1;
                        r_buf           <= {w_seed[47:0], {(BW-48){1'b0}}};
                        r_count         <= CW'(offset) + CW'(2);
                        r_payload_ready <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_STREAM, S_FLUSH: begin
                    r_buf           <= w_buf_nxt;
                    r_count         <= w_count_nxt;
                    r_payload_ready <= w_ready_nxt;
                    if (w_out_free) begin
                        r_data_valid <= w_pop;
                        if (w_pop) begin
                            r_data_out <= r_buf[BW-1 -: 32];
                        end
                    end
                    if ((r_state == S_STREAM) && w_push && payload_last) begin
                        r_state <= S_FLUSH;
                    end
                    if (w_frame_done) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign data_out      = r_data_out;
    assign data_valid    = r_data_valid;
    assign payload_ready = r_payload_ready;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = w_frame_done;

endmodule

// File: tb/tb_mac_frame_builder.sv
// Bench for mac_frame_builder: directed vector table, reset/clear sequences and
// random frames compared against a byte-queue model of the frame layout.
module tb_mac_frame_builder;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        start;
    logic [47:0] mac_in;
    logic [1:0]  offset;
    logic [31:0] payload_in;
    logic        payload_valid;
    logic        payload_last;
    logic        payload_ready;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    mac_frame_builder #(.BUF_BYTES(12)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .start(start),
        .mac_in(mac_in), .offset(offset), .payload_in(payload_in),
        .payload_valid(payload_valid), .payload_last(payload_last),
        .payload_ready(payload_ready), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy), .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pay_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    typedef struct {
        string            name;
        logic [47:0]      mac;
        logic [1:0]       off;
        int               npay;
        logic [2:0][31:0] pay;
        int               rmode;
        int               nexp;
        logic [4:0][31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: lay the frame out as a byte list, pad to a word, then cut words.
    function automatic void build_expected(input logic [47:0] mac, input int off);
        logic [7:0]  bq[$];
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < off; i++) bq.push_back(8'h00);
        for (int i = 0; i < 6; i++) bq.push_back(mac[47 - 8*i -: 8]);
        foreach (pay_q[k]) begin
            w = pay_q[k];
            for (int i = 0; i < 4; i++) bq.push_back(w[31 - 8*i -: 8]);
        end
        while (bq.size() % 4 != 0) bq.push_back(8'h00);
        for (int i = 0; i < bq.size(); i += 4)
            exp_q.push_back({bq[i], bq[i+1], bq[i+2], bq[i+3]});
    endfunction

    // rmode: 0 ready always, 1 ready toggling 1/0, 2 random; vrand: random payload_valid.
    task automatic run_frame(input string name, input logic [47:0] mac, input logic [1:0] off,
                             input int rmode, input bit vrand);
        int          nexp = exp_q.size();
        int          npay = pay_q.size();
        int          pi   = 0;
        int          cyc  = 0;
        bit          done = 1'b0;
        bit          held_v = 1'b0;
        logic [31:0] held = '0;
        got_q.delete();
        mac_in = mac; offset = off; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mac_in = {16'($urandom), $urandom};
        offset = 2'($urandom);
        while (!done && cyc < 400) begin
            data_ready    = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            payload_valid = (pi < npay) && (!vrand || ($urandom_range(0, 3) != 0));
            payload_in    = (pi < npay) ? pay_q[pi] : $urandom;
            payload_last  = (pi == npay - 1);
            @(negedge clk);
            if (cyc == 0) check({name, " first_valid_latency"}, 32'(data_valid), 32'd1);
            if (held_v) begin
                check({name, " stall_hold_data"}, data_out, held);
                check({name, " stall_hold_valid"}, 32'(data_valid), 32'd1);
            end
            held_v = data_valid && !data_ready;
            held   = data_out;
            if (data_valid && data_ready) begin
                got_q.push_back(data_out);
                check({name, " frame_done"}, 32'(frame_done), 32'(got_q.size() == nexp));
                if (got_q.size() == nexp) done = 1'b1;
            end else begin
                check({name, " frame_done_idle"}, 32'(frame_done), 32'd0);
            end
            if (payload_valid && payload_ready) pi++;
            @(posedge clk); #1;
            cyc++;
        end
        payload_valid = 1'b0;
        payload_last  = 1'b0;
        check({name, " completed"}, 32'(done), 32'd1);
        check({name, " payload_consumed"}, 32'(pi), 32'(npay));
        check({name, " word_count"}, 32'(got_q.size()), 32'(nexp));
        for (int i = 0; i < got_q.size() && i < nexp; i++)
            check($sformatf("%s word%0d", name, i), got_q[i], exp_q[i]);
        check({name, " busy_after"}, 32'(busy), 32'd0);
    endtask

    function automatic vec_t mk(input string name, input logic [47:0] mac, input logic [1:0] off,
                                input int npay, input logic [95:0] pay, input int rmode,
                                input int nexp, input logic [159:0] exp);
        vec_t v;
        v.name = name; v.mac = mac; v.off = off; v.npay = npay; v.rmode = rmode; v.nexp = nexp;
        for (int i = 0; i < 3; i++) v.pay[i] = pay[95 - 32*i -: 32];
        for (int i = 0; i < 5; i++) v.exp[i] = exp[159 - 32*i -: 32];
        return v;
    endfunction

    task automatic load_vec(input int k);
        pay_q.delete();
        exp_q.delete();
        for (int i = 0; i < vecs[k].npay; i++) pay_q.push_back(vecs[k].pay[i]);
        for (int i = 0; i < vecs[k].nexp; i++) exp_q.push_back(vecs[k].exp[i]);
    endtask

    initial begin
        vecs[0] = mk("off0", 48'h01B2C3D4E5F6, 2'd0, 1, {32'hAABBCCDD, 64'h0}, 0, 3,
                     {32'h01B2C3D4, 32'hE5F6AABB, 32'hCCDD0000, 64'h0});
        vecs[1] = mk("off1", 48'h01B2C3D4E5F6, 2'd1, 1, {32'hAABBCCDD, 64'h0}, 0, 3,
                     {32'h0001B2C3, 32'hD4E5F6AA, 32'hBBCCDD00, 64'h0});
        vecs[2] = mk("off2", 48'h01B2C3D4E5F6, 2'd2, 1, {32'hAABBCCDD, 64'h0}, 0, 3,
                     {32'h000001B2, 32'hC3D4E5F6, 32'hAABBCCDD, 64'h0});
        vecs[3] = mk("off3", 48'h01B2C3D4E5F6, 2'd3, 1, {32'hAABBCCDD, 64'h0}, 0, 4,
                     {32'h00000001, 32'hB2C3D4E5, 32'hF6AABBCC, 32'hDD000000, 32'h0});
        vecs[4] = mk("backpressure", 48'h01B2C3D4E5F6, 2'd2, 3,
                     {32'h11111111, 32'h22222222, 32'h33333333}, 1, 5,
                     {32'h000001B2, 32'hC3D4E5F6, 32'h11111111, 32'h22222222, 32'h33333333});
        vecs[5] = mk("all_ones", '1, 2'd0, 1, {32'hFFFFFFFF, 64'h0}, 0, 3,
                     {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF0000, 64'h0});

        n_rst = 1'b0; clear = 1'b0; start = 1'b0; mac_in = '0; offset = '0;
        payload_in = '0; payload_valid = 1'b0; payload_last = 1'b0; data_ready = 1'b0;
        #12;
        check("reset data_valid", 32'(data_valid), 32'd0);
        check("reset data_out", data_out, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset payload_ready", 32'(payload_ready), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) begin
            load_vec(k);
            run_frame(vecs[k].name, vecs[k].mac, vecs[k].off, vecs[k].rmode, 1'b0);
            @(posedge clk); #1;
        end

        // Async reset after the first word has gone out.
        mac_in = 48'h01B2C3D4E5F6; offset = 2'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_ready = 1'b1;
        @(posedge clk); #1;
        #2 n_rst = 1'b0;
        #1;
        check("midreset data_valid", 32'(data_valid), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset data_out", data_out, 32'd0);
        check("midreset payload_ready", 32'(payload_ready), 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        load_vec(0);
        run_frame("after_reset", vecs[0].mac, vecs[0].off, 0, 1'b0);

        // clear and start together in STREAM.
        mac_in = 48'h01B2C3D4E5F6; offset = 2'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b1; start = 1'b1; mac_in = 48'hDEADBEEF0123; offset = 2'd3;
        @(negedge clk);
        check("clear frame_done", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; start = 1'b0;
        check("clear data_valid", 32'(data_valid), 32'd0);
        check("clear busy", 32'(busy), 32'd0);
        check("clear payload_ready", 32'(payload_ready), 32'd0);
        @(posedge clk); #1;
        check("clear no_frame", 32'(busy), 32'd0);
        load_vec(2);
        run_frame("after_clear", vecs[2].mac, vecs[2].off, 0, 1'b0);

        // Random frames against the byte-level model.
        for (int f = 0; f < 25; f++) begin
            logic [47:0] m;
            logic [1:0]  o;
            int          np;
            m  = {16'($urandom), $urandom};
            o  = 2'($urandom_range(0, 3));
            np = $urandom_range(1, 6);
            pay_q.delete();
            for (int i = 0; i < np; i++) pay_q.push_back($urandom);
            build_expected(m, int'(o));
            run_frame($sformatf("rand%0d", f), m, o, 2, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_frame_builder.md
Name: mac_frame_builder

Overview:
Transmit-side counterpart to the MAC comparator. It builds the 32-bit word stream the sniffer datapath carries. Each frame is a programmable number of leading zero bytes (0-3), then a 48-bit MAC, then a byte-realigned payload word stream, with the final word zero-padded. It feeds the comparator bench and loopback paths with streams that have a MAC at any byte alignment.

Parameters:
BUF_BYTES, 12, depth of the internal byte accumulator in bytes; must be >= 10.

Ports:
clk  in  1  system clock; all state updates on rising edge
n_rst  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; drops the frame in progress and empties the accumulator
start  in  1  begin frame; sampled only in IDLE
mac_in  in  48  MAC to insert; mac_in[47:40] is the first byte on the wire
offset  in  2  number of zero bytes before the MAC (0-3)
payload_in  in  32  payload word; bits [31:24] are the first byte
payload_valid  in  1  payload word present
payload_last  in  1  qualifies the final payload word of the frame
payload_ready  out  1  payload word accepted this cycle when high together with payload_valid
data_out  out  32  output word; bits [31:24] are the first byte
data_valid  out  1  data_out holds a valid word
data_ready  in  1  downstream accepts data_out this cycle
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle pulse in the cycle the last word of the frame is accepted

Behaviour:
- Reset (n_rst low, async): state=IDLE; accumulator empty (count=0); data_out=0, data_valid=0, payload_ready=0, busy=0, frame_done=0.
- Byte order: big-endian within a word. The first byte in the frame occupies data_out[31:24].
- Accumulator: a BUF_BYTES-deep byte FIFO with a byte count.
  - Bytes are appended at the tail.
  - Words are taken from the head, 4 bytes at a time.
- States: IDLE, LOAD, STREAM, FLUSH.
- IDLE:
  - On start=1 (and clear=0), load offset zero bytes followed by the 6 MAC bytes into the accumulator (count = offset+6) and go to STREAM.
  - mac_in and offset are sampled only in this cycle.
  - LOAD is a legal single-cycle alias for this action; if the implementation does not need it, it is encoded but unreachable.
  - start while busy is ignored.
- STREAM:
  - payload_ready = (count + 4 <= BUF_BYTES) and the last word has not yet been accepted.
  - Each accepted payload word appends 4 bytes.
  - Accepting a word with payload_last=1 moves the FSM to FLUSH.
- Output register:
  - Loads when data_valid=0 or data_ready=1.
  - In STREAM it loads only when count >= 4, counting bytes already present this cycle; it then pops 4 bytes and sets data_valid=1.
  - If it has nothing to load, data_valid goes 0.
  - A payload append and a word pop in the same cycle are both legal; the count updates by +4-4.
- FLUSH:
  - Emit words while count >= 4.
  - When 0 < count < 4, emit the remaining bytes in the high byte lanes with the low lanes zero, then set count=0.
  - When count=0 and the last word has been accepted (data_valid & data_ready), pulse frame_done and return to IDLE.
- Latency:
  - First data_valid is asserted the cycle after start.
  - Sustained throughput is 1 word per cycle when payload_valid=1 and data_ready=1.
- Frame length: total words = ceil((offset + 6 + 4N) / 4), where N >= 1 payload words. A frame with no payload is not supported.
- Backpressure: while data_valid=1 and data_ready=0, data_out holds stable. payload_ready deasserts once the accumulator cannot take 4 more bytes.
- clear=1:
  - Next state is IDLE, count=0, data_valid=0, payload_ready=0, frame_done=0.
  - clear has priority over start and over all handshakes in that cycle.
- Async reset mid-frame: same result as clear, applied immediately. No partial word is emitted afterwards.

Test Plan:
- Reset: assert n_rst=0 mid-frame (after 1 word out) -> data_valid=0, busy=0, data_out=0 immediately; the next start produces a clean frame.
- Offset 0: mac_in=48'h01B2C3D4E5F6, payload 32'hAABBCCDD (last), data_ready=1 -> words 01B2C3D4, E5F6AABB, CCDD0000; frame_done pulses with the third word.
- Offsets 1/2/3, same MAC and payload:
  - offset 1 -> 0001B2C3, D4E5F6AA, BBCCDD00
  - offset 2 -> 000001B2, C3D4E5F6, AABBCCDD
  - offset 3 -> 00000001, B2C3D4E5, F6AABBCC, DD000000
- Backpressure: offset 2, 3 payload words 11111111/22222222/33333333, data_ready toggling 1/0 -> output is exactly 000001B2, C3D4E5F6, 11111111, 22222222, 33333333 with no drops or duplicates; data_out is stable while stalled.
- All-ones: mac_in='1, offset 0, payload FFFFFFFF -> FFFFFFFF, FFFFFFFF, FFFF0000. Feeding this to mac_comparator with flagged_mac='1 produces match=1.
- Clear/start collision: clear=1 and start=1 in the same cycle during STREAM -> IDLE, data_valid=0 next cycle, no frame started. A start on the following cycle produces a correct frame.
